// File: rtl/flow_valve_sequencer.sv
// Reservoir inlet valve sequencer: moves one valve at a time toward the level
// controller's demand, confirms each move by acknowledge, and latches actuator faults.
module flow_valve_sequencer #(
    parameter int STAGGER     = 16,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_fr1,
    input  logic       req_fr2,
    input  logic       req_fr3,
    input  logic       req_dfr,
    input  logic [3:0] valve_ack,
    input  logic       clr_fault,
    output logic [3:0] valve_open,
    output logic       busy,
    output logic       fault,
    output logic [1:0] fault_valve
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_OPEN  = 3'd1,
        ST_WAIT_CLOSE = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    logic [3:0]       target_s;
    logic [3:0]       drift_s;
    logic [3:0]       close_s;
    logic [3:0]       open_s;
    logic             ack_match_s;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

    function automatic logic [1:0] highest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

    // Demand decode and handshake match for the valve currently being moved.
    always_comb begin
        target_s    = {req_dfr, req_fr3, req_fr2, req_fr1};
        drift_s     = valve_ack ^ valve_open;
        close_s     = valve_open & ~target_s;
        open_s      = ~valve_open & target_s;
        ack_match_s = (valve_ack[idx_r] == valve_open[idx_r]);
        busy        = (state_r != ST_IDLE) || (target_s != valve_open);
    end

    // Sequencer FSM with registered valve commands and fault reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 2'd0;
            valve_open  <= 4'b0000;
            fault       <= 1'b0;
            fault_valve <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (|drift_s) begin
                        state_r     <= ST_FAULT;
                        valve_open  <= 4'b0000;
                        fault       <= 1'b1;
                        fault_valve <= lowest_idx(drift_s);
                    end else if (|close_s) begin
                        idx_r                         <= highest_idx(close_s);
                        valve_open[highest_idx(close_s)] <= 1'b0;
                        state_r                       <= ST_WAIT_CLOSE;
                    end else if (|open_s) begin
                        idx_r                        <= lowest_idx(open_s);
                        valve_open[lowest_idx(open_s)] <= 1'b1;
                        state_r                      <= ST_WAIT_OPEN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_OPEN, ST_WAIT_CLOSE: begin
                    if (ack_match_s) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= (state_r == ST_WAIT_OPEN) ? ST_SETTLE : ST_IDLE;
                    end else if (cnt_r == ACK_LAST) begin
                        cnt_r       <= CNT_ZERO;
                        state_r     <= ST_FAULT;
                        valve_open  <= 4'b0000;
                        fault       <= 1'b1;
                        fault_valve <= idx_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_FAULT: begin
                    cnt_r      <= CNT_ZERO;
                    valve_open <= 4'b0000;
                    if (clr_fault) begin
                        state_r     <= ST_IDLE;
                        fault       <= 1'b0;
                        fault_valve <= 2'd0;
                    end else begin
                        state_r <= ST_FAULT;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    valve_open <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flow_valve_sequencer.sv
// Directed bench for flow_valve_sequencer with a 1-cycle actuator model and a
// scoreboard of expected valve_open steps and their cycle spacing.
module tb_flow_valve_sequencer;

    typedef struct {
        logic [3:0] vo;
        int         gap;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       req_fr1, req_fr2, req_fr3, req_dfr;
    logic [3:0] valve_ack;
    logic       clr_fault;
    logic [3:0] valve_open;
    logic       busy;
    logic       fault;
    logic [1:0] fault_valve;

    logic [3:0] ack_reg;
    logic [3:0] ack_mask;
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    flow_valve_sequencer #(.STAGGER(16), .ACK_TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_fr1(req_fr1), .req_fr2(req_fr2), .req_fr3(req_fr3), .req_dfr(req_dfr),
        .valve_ack(valve_ack), .clr_fault(clr_fault),
        .valve_open(valve_open), .busy(busy), .fault(fault), .fault_valve(fault_valve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Actuator: position follows command one cycle later; mask forces stuck-closed bits.
    always @(posedge clk or negedge reset) begin
        if (!reset) ack_reg <= 4'b0000;
        else        ack_reg <= valve_open;
    end
    assign valve_ack = ack_reg & ~ack_mask;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        {req_dfr, req_fr3, req_fr2, req_fr1} = r;
    endtask

    task automatic push(input logic [3:0] vo, input int gap);
        exp_t e;
        e.vo  = vo;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_vo(input string tag, input logic [3:0] want);
        for (int i = 0; i < 200 && valve_open !== want; i++) @(negedge clk);
        chk(tag, valve_open, want);
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
    endtask

    // Scoreboard: every change of valve_open must match the next queued step.
    initial begin
        logic [3:0] prev_vo;
        int         last_cyc;
        exp_t       e;
        prev_vo  = 4'b0000;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (valve_open !== prev_vo) begin
                checks = checks + 1;
                assert (exp_q.size() > 0) else begin
                    errors = errors + 1;
                    $error("FAIL unexpected_step observed=%b expected=none", valve_open);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks = checks + 1;
                    assert (valve_open === e.vo) else begin
                        errors = errors + 1;
                        $error("FAIL step_value observed=%b expected=%b", valve_open, e.vo);
                    end
                    if (e.gap != 0) begin
                        checks = checks + 1;
                        assert ((cyc - last_cyc) == e.gap) else begin
                            errors = errors + 1;
                            $error("FAIL step_gap observed=%0d expected=%0d", cyc - last_cyc, e.gap);
                        end
                    end
                end
                prev_vo  = valve_open;
                last_cyc = cyc;
            end
        end
    end

    initial begin
        reset     = 1'b0;
        clr_fault = 1'b0;
        ack_mask  = 4'b0000;
        set_req(4'b0000);
        repeat (3) @(negedge clk);
        chk("reset_valve_open", valve_open, 4'b0000);
        chk("reset_fault", fault, 1'b0);
        chk("reset_fault_valve", fault_valve, 2'd0);
        chk("reset_busy", busy, 1'b0);

        // Open all four, fr1 first, 19 cycles apart.
        set_req(4'b1111);
        push(4'b0001, 0); push(4'b0011, 19); push(4'b0111, 19); push(4'b1111, 19);
        reset = 1'b1;
        wait_vo("open_all", 4'b1111);
        repeat (17) @(negedge clk);
        chk("busy_in_settle", busy, 1'b1);
        @(negedge clk);
        chk("busy_after_settle", busy, 1'b0);

        // Close all, dfr first, 3 cycles apart.
        set_req(4'b0000);
        push(4'b0111, 0); push(4'b0011, 3); push(4'b0001, 3); push(4'b0000, 3);
        wait_vo("close_all", 4'b0000);
        repeat (2) @(negedge clk);
        chk("busy_after_close", busy, 1'b0);
        chk("no_fault_after_close", fault, 1'b0);

        // fr3 actuator stuck closed: timeout fault after 8 cycles.
        ack_mask = 4'b0100;
        set_req(4'b1111);
        push(4'b0001, 0); push(4'b0011, 19); push(4'b0111, 19); push(4'b0000, 8);
        wait_vo("open_to_fr3", 4'b0111);
        repeat (7) @(negedge clk);
        chk("timeout_not_yet", fault, 1'b0);
        @(negedge clk);
        chk("timeout_fault", fault, 1'b1);
        chk("timeout_fault_valve", fault_valve, 2'd2);
        chk("timeout_all_closed", valve_open, 4'b0000);

        // Clear once acks read closed; sequence restarts from fr1.
        repeat (2) @(negedge clk);
        chk("acks_closed", valve_ack, 4'b0000);
        chk("fault_held", fault, 1'b1);
        ack_mask = 4'b0000;
        set_req(4'b0011);
        push(4'b0001, 0); push(4'b0011, 19);
        pulse_clr();
        chk("clear_fault", fault, 1'b0);
        chk("clear_fault_valve", fault_valve, 2'd0);
        @(negedge clk);
        chk("restart_fr1", valve_open, 4'b0001);
        wait_vo("restart_0011", 4'b0011);
        repeat (18) @(negedge clk);

        // Drift on fr1 while steady at 0011.
        ack_mask = 4'b0001;
        push(4'b0000, 0);
        @(negedge clk);
        chk("drift_fault", fault, 1'b1);
        chk("drift_fault_valve", fault_valve, 2'd0);
        chk("drift_all_closed", valve_open, 4'b0000);
        ack_mask = 4'b0000;
        repeat (2) @(negedge clk);
        push(4'b0001, 0); push(4'b0011, 19);
        pulse_clr();
        wait_vo("drift_recover", 4'b0011);
        repeat (18) @(negedge clk);

        // Close fr2 and open fr3 in the same request change: close goes first.
        set_req(4'b0101);
        push(4'b0001, 0); push(4'b0101, 3);
        wait_vo("swap", 4'b0101);
        repeat (18) @(negedge clk);
        chk("swap_final", valve_open, 4'b0101);
        chk("swap_busy", busy, 1'b0);

        // Reset in the middle of WAIT_OPEN, then a clean restart.
        set_req(4'b0111);
        push(4'b0111, 0); push(4'b0000, 0);
        push(4'b0001, 0); push(4'b0011, 19); push(4'b0111, 19);
        wait_vo("mid_open", 4'b0111);
        reset = 1'b0;
        #1;
        chk("midreset_valve_open", valve_open, 4'b0000);
        chk("midreset_fault", fault, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wait_vo("post_reset_reopen", 4'b0111);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
